// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction word stream handshake plus instruction-memory write bus
// slave  (loader): takes in_valid/in_data, drives in_ready and imem_we/imem_addr/imem_wdata
// master (source): drives in_valid/in_data, observes everything else
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport slave(input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
  modport master(output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming words into imem from address 0, holding the cpu in reset until loaded
// ports: clk, rst (sync, active high); start/len request a load; bus carries the word handshake and imem writes;
// cpu_rst holds the processor, busy = LOAD|HOLD, done = RUN, err pulses on a rejected start, checksum sums accepted words
module imem_loader #(
  parameter int ADDR_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_loader_if.slave      bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [31:0]       sum_q, sum_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, err_q, err_d;
  logic              ready_q, ready_d, cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d;
  logic              len_ok, hs, sampling;
  assign len_ok   = len != '0 && len <= DEPTH;
  assign hs       = bus.in_valid && ready_q;
  assign sampling = start && (state_q == IDLE || state_q == RUN);
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hcnt_d  = hcnt_q;
    err_d   = sampling && !len_ok;
    we_d    = hs;
    addr_d  = hs ? cnt_q[ADDR_W-1:0] : addr_q;
    wdata_d = hs ? bus.in_data : wdata_q;
    cnt_d   = hs ? cnt_q + 1'b1 : cnt_q;
    sum_d   = hs ? sum_q + bus.in_data : sum_q;
    if (sampling && len_ok) begin
      state_d = LOAD;
      len_d   = len;
      cnt_d   = '0;
      sum_d   = '0;
    end
    if (hs && cnt_d == len_q) begin
      state_d = HOLD;
      hcnt_d  = '0;
    end
    if (state_q == HOLD) begin
      state_d = hcnt_q == HW'(HOLD_CYC - 1) ? RUN : HOLD;
      hcnt_d  = hcnt_q + 1'b1;
    end
    ready_d   = state_d == LOAD;
    cpu_rst_d = state_d != RUN;
    busy_d    = state_d == LOAD || state_d == HOLD;
    done_d    = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      hcnt_q    <= '0;
      sum_q     <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      hcnt_q    <= hcnt_d;
      sum_q     <= sum_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign checksum       = sum_q;
endmodule
